// File: rtl/sum_residue_serial_if.sv
// rtl/sum_residue_serial_if.sv - handshake bundle for the serial sum-residue solver
interface sum_residue_serial_if #(
  parameter int WIDTH   = 5,
  parameter int NUM_OPS = 11
);
  localparam int CW = $clog2(NUM_OPS);

  logic             sum_valid;
  logic [WIDTH-1:0] sum_in;
  logic             sum_ready;
  logic             op_valid;
  logic [WIDTH-1:0] op_in;
  logic             op_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_out;
  logic             res_ready;
  logic             busy;
  logic [CW-1:0]    op_count;

  modport slave (
    input  sum_valid, sum_in, op_valid, op_in, res_ready,
    output sum_ready, op_ready, res_valid, res_out, busy, op_count
  );

  modport master (
    output sum_valid, sum_in, op_valid, op_in, res_ready,
    input  sum_ready, op_ready, res_valid, res_out, busy, op_count
  );
endinterface

// File: rtl/sum_residue_serial.sv
// rtl/sum_residue_serial.sv - recovers the missing operand of an NUM_OPS-input modular sum
module sum_residue_serial #(
  parameter int WIDTH   = 5,
  parameter int NUM_OPS = 11
) (
  input logic               clk,
  input logic               rst,
  sum_residue_serial_if.slave bus
);
  localparam int            CW       = $clog2(NUM_OPS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OPS - 2);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt;
  logic             sum_fire;
  logic             op_fire;
  logic             res_fire;
  logic             last_op;
  logic [WIDTH-1:0] acc_sub;

  assign sum_fire = (state == IDLE)    && bus.sum_valid;
  assign op_fire  = (state == COLLECT) && bus.op_valid;
  assign res_fire = (state == DONE)    && bus.res_ready;
  assign last_op  = op_fire && (cnt == LAST_IDX);
  assign acc_sub  = acc - bus.op_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sum_fire) state_nxt = COLLECT;
      COLLECT: if (last_op)  state_nxt = DONE;
      DONE:    if (res_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // res_q is loaded with the post-subtraction value so it already includes the last operand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else if (sum_fire) begin
      acc <= bus.sum_in;
      cnt <= '0;
    end else if (op_fire) begin
      acc <= acc_sub;
      cnt <= cnt + CW'(1);
      if (last_op) begin
        res_q <= acc_sub;
      end
    end else if (res_fire) begin
      cnt <= '0;
    end
  end

  assign bus.sum_ready = (state == IDLE);
  assign bus.op_ready  = (state == COLLECT);
  assign bus.res_valid = (state == DONE);
  assign bus.busy      = (state == COLLECT) || (state == DONE);
  assign bus.res_out   = res_q;
  assign bus.op_count  = cnt;
endmodule

// File: tb/tb_sum_residue_serial.sv
// tb/tb_sum_residue_serial.sv - scoreboard bench for sum_residue_serial
module tb_sum_residue_serial;
  localparam int WIDTH   = 5;
  localparam int NUM_OPS = 11;
  localparam int NK      = NUM_OPS - 1;

  typedef struct {
    logic [WIDTH-1:0] exp;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] opsum;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   rand_rr = 1'b0;
  exp_t sb[$];
  exp_t mon_e;
  logic [WIDTH-1:0] ops[NK];

  sum_residue_serial_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) bus();

  sum_residue_serial #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", name);
  endtask

  // Monitor: a handshake seen at the falling edge completes at the next rising edge
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_result");
      end else begin
        mon_e = sb.pop_front();
        chk("res_out", bus.res_out, mon_e.exp);
        chk("adder_total", WIDTH'(bus.res_out + mon_e.opsum), mon_e.sum);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rr) bus.res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic give_sum(input logic [WIDTH-1:0] s);
    bit ok;
    ok = 1'b0;
    bus.sum_valid = 1'b1;
    bus.sum_in    = s;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.sum_ready;
      @(posedge clk);
      #1;
    end
    bus.sum_valid = 1'b0;
    if (!ok) fail_now("sum_accept_timeout");
  endtask

  task automatic give_op(input logic [WIDTH-1:0] v, input int gap);
    bit ok;
    ok = 1'b0;
    bus.op_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b1;
    bus.op_in    = v;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus.op_ready;
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b0;
    if (!ok) fail_now("op_accept_timeout");
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e);
    exp_t x;
    logic [WIDTH-1:0] os;
    os = '0;
    for (int i = 0; i < NK; i++) os = os + ops[i];
    x.exp   = e;
    x.sum   = s;
    x.opsum = os;
    sb.push_back(x);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      fail_now(name);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] os;

    bus.sum_valid = 1'b0;
    bus.sum_in    = '0;
    bus.op_valid  = 1'b0;
    bus.op_in     = '0;
    bus.res_ready = 1'b0;
    #22 rst = 1'b0;

    @(negedge clk);
    chk("rst_sum_ready", bus.sum_ready, 1);
    chk("rst_op_ready", bus.op_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_out", bus.res_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_op_count", bus.op_count, 0);
    @(posedge clk);
    #1;

    // Basic: 0 - 10*1 = 22
    bus.res_ready = 1'b1;
    for (int i = 0; i < NK; i++) ops[i] = 5'd1;
    push_exp(5'd0, 5'd22);
    give_sum(5'd0);
    t0 = cyc;
    for (int i = 0; i < NK; i++) give_op(ops[i], 0);
    chk("basic_latency", cyc - t0, 10);
    @(negedge clk);
    chk("basic_res_valid_hi", bus.res_valid, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("basic_res_valid_lo", bus.res_valid, 0);
    chk("basic_sum_ready_next", bus.sum_ready, 1);
    drain("basic_drain");

    // Wrap: 31 - (0+..+9) = 18, op_count walks 0..10
    for (int i = 0; i < NK; i++) ops[i] = 5'(i);
    push_exp(5'd31, 5'd18);
    give_sum(5'd31);
    @(negedge clk);
    chk("wrap_op_count_0", bus.op_count, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NK; i++) begin
      give_op(ops[i], 0);
      @(negedge clk);
      chk("wrap_op_count", bus.op_count, i + 1);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("wrap_op_count_cleared", bus.op_count, 0);
    drain("wrap_drain");

    // Gaps and backpressure: 5 - 30 = 7
    bus.res_ready = 1'b0;
    for (int i = 0; i < NK; i++) ops[i] = 5'd3;
    push_exp(5'd5, 5'd7);
    give_sum(5'd5);
    t0 = cyc;
    for (int i = 0; i < NK; i++) give_op(ops[i], 1);
    chk("gap_latency", cyc - t0, 20);
    for (int k = 0; k < 5; k++) begin
      bus.sum_valid = 1'b1;
      bus.sum_in    = 5'(k + 20);
      bus.op_valid  = 1'b1;
      bus.op_in     = 5'(k + 1);
      @(negedge clk);
      chk("bp_res_out", bus.res_out, 7);
      chk("bp_res_valid", bus.res_valid, 1);
      chk("bp_sum_ready", bus.sum_ready, 0);
      chk("bp_op_ready", bus.op_ready, 0);
      chk("bp_op_count", bus.op_count, 10);
      @(posedge clk);
      #1;
    end
    bus.sum_valid = 1'b0;
    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_res_valid_lo", bus.res_valid, 0);
    chk("bp_res_out_kept", bus.res_out, 7);
    drain("bp_drain");

    // Ignored operands in IDLE
    bus.op_valid = 1'b1;
    bus.op_in    = 5'd9;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_op_count", bus.op_count, 0);
      chk("idle_op_ready", bus.op_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.op_valid = 1'b0;
    for (int i = 0; i < NK; i++) ops[i] = 5'd0;
    push_exp(5'd10, 5'd10);
    give_sum(5'd10);
    for (int i = 0; i < NK; i++) give_op(ops[i], 0);
    drain("idle_drain");

    // Asynchronous reset mid-transaction
    give_sum(5'd7);
    for (int i = 0; i < 4; i++) give_op(5'd1, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_res_valid", bus.res_valid, 0);
    chk("arst_op_count", bus.op_count, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_op_ready", bus.op_ready, 0);
    chk("arst_res_out", bus.res_out, 0);
    #10 rst = 1'b0;
    @(negedge clk);
    chk("arst_sum_ready", bus.sum_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < NK; i++) ops[i] = 5'd31;
    push_exp(5'd0, 5'd10);
    give_sum(5'd0);
    for (int i = 0; i < NK; i++) give_op(ops[i], 0);
    drain("arst_drain");

    // Random cross-check with stalls on both sides
    rand_rr = 1'b1;
    for (int t = 0; t < 200; t++) begin
      s  = 5'($urandom);
      os = '0;
      for (int i = 0; i < NK; i++) begin
        ops[i] = 5'($urandom);
        os = os + ops[i];
      end
      push_exp(s, s - os);
      give_sum(s);
      for (int i = 0; i < NK; i++) give_op(ops[i], int'($urandom_range(0, 2)));
    end
    drain("rand_drain");
    rand_rr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sum_residue_serial.md
# sum_residue_serial

Serial inverse of the team's 11-operand modular adder. It accepts a WIDTH-bit target total, then streams in NUM_OPS-1 known operands through a valid/ready handshake. It returns the single missing operand x that satisfies total = x + sum(known operands) mod 2^WIDTH. It serves as the checker/solver at the far end of the 11-input sum datapath, and benches use it to regenerate the 11th operand.

## Interface
- WIDTH, 5, bit width of the total, the operands and the result; all arithmetic is mod 2^WIDTH
- NUM_OPS, 11, operand count of the forward adder; the block consumes NUM_OPS-1 operands per transaction
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- sum_valid  input  1  target total offered
- sum_in  input  WIDTH  target total
- sum_ready  output  1  block accepts a total; high only in IDLE
- op_valid  input  1  known operand offered
- op_in  input  WIDTH  known operand
- op_ready  output  1  block accepts an operand; high only in COLLECT
- res_valid  output  1  recovered operand available
- res_out  output  WIDTH  recovered operand x
- res_ready  input  1  downstream consumes the result
- busy  output  1  high in COLLECT or DONE
- op_count  output  $clog2(NUM_OPS)  number of operands accepted in the current transaction

## Operation
- State machine states: IDLE, COLLECT, DONE. All outputs come from registers or decode directly from the state register; no combinational input-to-output paths.
- IDLE: sum_ready=1. When sum_valid and sum_ready are both high, set acc <= sum_in and op_count <= 0, then go to COLLECT.
- COLLECT: op_ready=1. When op_valid and op_ready are both high, set acc <= acc - op_in (WIDTH-bit, borrow discarded) and op_count <= op_count+1.
  - When the accepted operand is number NUM_OPS-1, the next state is DONE. res_out is loaded with the final acc value (including this operand).
- DONE: res_valid=1, and res_out holds steady.
  - When res_valid and res_ready are both high, go to IDLE, clear res_valid, and clear op_count. res_out keeps its last value.
- Inputs are ignored outside their state: op_valid in IDLE or DONE, and sum_valid in COLLECT or DONE. Each ignored input has no effect on acc or op_count.
- Backpressure: DONE holds indefinitely while res_ready=0. No new total is accepted until the result is consumed.
- Wrap-around: sums and differences wrap mod 2^WIDTH. For example, 0-1 gives 2^WIDTH-1.
- Reset, asserted at any time including mid-transaction:
  - state = IDLE, acc = 0, op_count = 0, res_valid = 0, res_out = 0
  - sum_ready = 1 once reset is released; op_ready = 0; busy = 0
  - A partial transaction is discarded without producing any output.

## Timing
- Reset values: sum_ready=1, op_ready=0, res_valid=0, res_out=0, busy=0, op_count=0.
- Total accepted at edge t. With op_valid held high, operands are accepted at edges t+1 through t+NUM_OPS-1 (t+10 at the defaults).
- res_valid rises after edge t+NUM_OPS-1, so it is visible during cycle t+NUM_OPS. Minimum latency is NUM_OPS cycles from sum acceptance to result.
- Result consumed at edge r. sum_ready is high from cycle r+1, so there is one bubble cycle between transactions.
- Throughput: at most one operand per cycle. Gaps in op_valid stretch the latency by exactly the number of gap cycles.

## Test plan
- Basic, defaults: sum_in=0, then ten operands of value 1 back-to-back, res_ready=1 -> res_out=22 and res_valid high for exactly 1 cycle, 11 cycles after sum acceptance. Then sum_ready=1 on the following cycle.
- Wrap: sum_in=31, operands 0,1,…,9 -> res_out=18. Check that op_count steps 0→10.
- Backpressure and gaps: sum_in=5, operands all 3, with op_valid low on every other cycle, and res_ready held low for 5 cycles in DONE.
  - Expected res_out=7 (5-30 mod 32), held stable for all 5 cycles.
  - During those cycles: sum_ready=0 and op_ready=0, and sum_valid and op_valid pulses have no effect.
- Ignored inputs: in IDLE, drive op_valid=1 with op_in=9 for 3 cycles before the total. Then run sum_in=10 with ten operands of 0 -> res_out=10 (the IDLE operands are not counted).
- Reset mid-operation: assert rst asynchronously (off the clock edge) after 4 operands have been accepted.
  - Expected at once: res_valid=0, op_count=0, busy=0. After release, sum_ready=1.
  - A fresh transaction (sum_in=0, ten operands of 31) then yields res_out=10.
- Random cross-check: 200 transactions with random totals and operands and random valid/ready stalls. For each, feed res_out plus the ten known operands into the 11-operand adder -> the adder output equals sum_in every time.
